// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Step counter must hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_iterative_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] pr_i,
  input  logic             bit_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] pr_o,
  output logic             q_o
);

  logic [width:0] trial;
  logic           fits;

  // Only the low width bits of the new remainder are kept, so the subtraction
  // is done modulo 2^width; the carry-out bit still participates in the compare.
  always_comb begin
    trial = {pr_i, bit_i};
    fits  = (trial >= {1'b0, b_i});
    q_o   = fits;
    pr_o  = fits ? (trial[width-1:0] - b_i) : trial[width-1:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// Unsigned iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
module divider_iterative
  import divider_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned     CW   = cnt_width(width);
  localparam logic [CW-1:0]   LAST = CW'(width - 1);

  state_e           state_q, state_d;
  logic [width-1:0] a_sh_q, a_sh_d;
  logic [width-1:0] b_q, b_d;
  logic [width-1:0] pr_q, pr_d;
  logic [width-1:0] q_q, q_d;
  logic [width-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] step_pr;
  logic             step_bit;
  logic             accept;

  div_step #(.width(width)) u_step (
    .pr_i  (pr_q),
    .bit_i (a_sh_q[width-1]),
    .b_i   (b_q),
    .pr_o  (step_pr),
    .q_o   (step_bit)
  );

  assign accept = start && (state_q != RUN);

  // Quotient bits enter a_sh from the bottom as dividend bits leave the top,
  // so after width steps a_sh holds the full quotient.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    pr_d    = pr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        pr_d   = step_pr;
        a_sh_d = {a_sh_q[width-2:0], step_bit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          q_d     = {a_sh_q[width-2:0], step_bit};
          r_d     = step_pr;
          dbz_d   = (b_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          a_sh_d  = a;
          b_d     = b;
          pr_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      pr_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative at width 8, plus a width-16 instance for multiply round-trips.
module tb_divider_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done, dbz;
  logic [7:0]  q, r;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16, dbz16;
  logic [15:0] q16, r16;

  int          total = 0;
  int          bad = 0;
  logic [31:0] xs;

  always #5 clk = ~clk;

  divider_iterative #(.width(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (dbz)
  );

  divider_iterative #(.width(16)) u_dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start16),
    .a           (a16),
    .b           (b16),
    .busy        (busy16),
    .done        (done16),
    .q           (q16),
    .r           (r16),
    .div_by_zero (dbz16)
  );

  function automatic logic [31:0] xorshift(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Reference: plain integer division; divide-by-zero yields all-ones quotient and remainder = dividend.
  function automatic void ref_div(input int unsigned av, input int unsigned bv, input int unsigned w,
                                  output int unsigned qe, output int unsigned re);
    if (bv == 0) begin
      qe = (32'd1 << w) - 1;
      re = av;
    end else begin
      qe = av / bv;
      re = av % bv;
    end
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] qo, output logic [7:0] ro, output logic zo,
                        output int lat, output logic overlap);
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    overlap = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy && done) overlap = 1'b1;
    end
    qo = q; ro = r; zo = dbz;
  endtask

  task automatic run_op16(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] qo, output logic [15:0] ro, output logic zo,
                          output int lat);
    @(posedge clk); #1;
    a16 = av; b16 = bv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    qo = q16; ro = r16; zo = dbz16;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, q, r, dbz} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d z=%b, want all zero", busy, done, q, r, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] av_t [6] = '{8'd200, 8'd5, 8'd255, 8'd255, 8'd0, 8'd1};
    logic [7:0] bv_t [6] = '{8'd7, 8'd9, 8'd1, 8'd255, 8'd3, 8'd255};
    logic [7:0] qo, ro;
    logic zo, ov;
    int lat;
    int unsigned qe, re;
    for (int i = 0; i < 6; i++) begin
      run_op(av_t[i], bv_t[i], qo, ro, zo, lat, ov);
      ref_div(av_t[i], bv_t[i], 8, qe, re);
      total++;
      if ({qo, ro, zo} !== {qe[7:0], re[7:0], 1'b0}) begin
        bad++;
        $display("FAIL directed_%0d: %0d/%0d got q=%0d r=%0d z=%b, want q=%0d r=%0d z=0",
                 i, av_t[i], bv_t[i], qo, ro, zo, qe, re);
      end
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL directed_latency_%0d: got %0d cycles, want 8", i, lat);
      end
      total++;
      if (ov !== 1'b0) begin
        bad++;
        $display("FAIL busy_done_overlap_%0d: got overlap=%b, want 0", i, ov);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] av_t [2] = '{8'd100, 8'd0};
    logic [7:0] qo, ro;
    logic zo, ov;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(av_t[i], 8'd0, qo, ro, zo, lat, ov);
      total++;
      if ({qo, ro, zo} !== {8'd255, av_t[i], 1'b1}) begin
        bad++;
        $display("FAIL div_zero_%0d: got q=%0d r=%0d z=%b, want q=255 r=%0d z=1", i, qo, ro, zo, av_t[i]);
      end
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL div_zero_latency_%0d: got %0d cycles, want 8", i, lat);
      end
    end
  endtask

  task automatic test_ignore_midrun();
    int lat;
    @(posedge clk); #1;
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        a = 8'd5; b = 8'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if ({q, r, dbz} !== {8'd28, 8'd4, 1'b0} || lat !== 8) begin
      bad++;
      $display("FAIL midrun_ignore: got q=%0d r=%0d z=%b lat=%0d, want q=28 r=4 z=0 lat=8", q, r, dbz, lat);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL midrun_not_queued: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    @(posedge clk); #1;
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd255; b = 8'd255;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if ({q, r} !== {8'd28, 8'd4} || lat !== 8) begin
      bad++;
      $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d, want q=28 r=4 lat=8", q, r, lat);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({busy, done, q, r} !== {1'b1, 1'b0, 8'd28, 8'd4}) begin
      bad++;
      $display("FAIL b2b_accept_hold: got busy=%b done=%b q=%0d r=%0d, want busy=1 done=0 q=28 r=4",
               busy, done, q, r);
    end
    lat2 = 0;
    while (!done && lat2 < 40) begin
      @(posedge clk); #1;
      lat2++;
    end
    total++;
    if ({q, r, dbz} !== {8'd1, 8'd0, 1'b0} || lat2 !== 8) begin
      bad++;
      $display("FAIL b2b_second: got q=%0d r=%0d z=%b lat=%0d, want q=1 r=0 z=0 lat=8", q, r, dbz, lat2);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] qo, ro;
    logic zo, ov;
    int lat;
    run_op(8'd100, 8'd0, qo, ro, zo, lat, ov);
    @(posedge clk); #1;
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, q, r, dbz} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d z=%b, want all zero", busy, done, q, r, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_discard: got busy=%b done=%b, want 0 0", busy, done);
    end
    run_op(8'd77, 8'd6, qo, ro, zo, lat, ov);
    total++;
    if ({qo, ro, zo} !== {8'd12, 8'd5, 1'b0} || lat !== 8) begin
      bad++;
      $display("FAIL after_reset_op: got q=%0d r=%0d z=%b lat=%0d, want q=12 r=5 z=0 lat=8", qo, ro, zo, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] av, bv, qo, ro;
    logic zo, ov;
    int lat;
    int unsigned qe, re;
    for (int i = 0; i < 20; i++) begin
      xs = xorshift(xs);
      av = xs[7:0];
      bv = (i % 5 == 0) ? 8'd0 : xs[15:8];
      run_op(av, bv, qo, ro, zo, lat, ov);
      ref_div(av, bv, 8, qe, re);
      total++;
      if ({qo, ro, zo} !== {qe[7:0], re[7:0], (bv == 8'd0)} || lat !== 8) begin
        bad++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=8",
                 i, av, bv, qo, ro, zo, lat, qe, re, (bv == 8'd0));
      end
      if (bv != 8'd0) begin
        total++;
        if ((int'(qo) * int'(bv) + int'(ro) != int'(av)) || (ro >= bv)) begin
          bad++;
          $display("FAIL random_identity_%0d: %0d/%0d got q=%0d r=%0d, want q*b+r==a and r<b",
                   i, av, bv, qo, ro);
        end
      end
    end
  endtask

  task automatic test_roundtrip16();
    logic [15:0] av, bv, p, qo, ro;
    logic zo;
    int lat;
    for (int i = 0; i < 6; i++) begin
      xs = xorshift(xs);
      av = {8'd0, xs[7:0]};
      bv = {8'd0, xs[15:8] | 8'd1};
      p  = av * bv;
      run_op16(p, bv, qo, ro, zo, lat);
      total++;
      if ({qo, ro, zo} !== {av, 16'd0, 1'b0} || lat !== 16) begin
        bad++;
        $display("FAIL roundtrip16_%0d: %0d/%0d got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=0 z=0 lat=16",
                 i, p, bv, qo, ro, zo, lat, av);
      end
    end
  endtask

  initial begin
    xs = $urandom | 32'h1;
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_midrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_roundtrip16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
